w4a8_gemm_int4_unpack: RTL and testbench
========================================

Name: w4a8_gemm_int4_unpack

Overview:
AXI4-Stream stage that sits directly downstream of the AXI read master in the W4A8 GEMM datapath. It consumes packed INT4 weight beats and emits INT8 bytes, so one input beat produces two output beats. Its output feeds the INT8 compute stage that occupies the slot the example adder fills today.

Parameters:
C_AXIS_TDATA_WIDTH, 512, input and output tdata width in bits; multiple of 16.
C_COUNT_WIDTH, 32, width of the output-beat statistics counter.

Ports:
ap_clk  in  1  kernel clock; all logic on rising edge
ap_rst_n  in  1  asynchronous active-low reset
ctrl_zero_point  in  4  unsigned INT4 zero point (used only with W4A8_GEMM_UNPACK_ZP_EN)
ctrl_clear  in  1  synchronous pulse; clears stat_out_beats
s_axis_tvalid  in  1  packed INT4 beat valid
s_axis_tready  out  1  ready for packed beat
s_axis_tdata  in  C_AXIS_TDATA_WIDTH  N=C_AXIS_TDATA_WIDTH/4 nibbles; nibble k = bits [4k+3:4k]
s_axis_tlast  in  1  last packed beat of transfer
m_axis_tvalid  out  1  INT8 beat valid
m_axis_tready  in  1  downstream ready
m_axis_tdata  out  C_AXIS_TDATA_WIDTH  N/2 INT8 bytes; byte j = bits [8j+7:8j]
m_axis_tlast  out  1  last INT8 beat of transfer
stat_out_beats  out  C_COUNT_WIDTH  count of completed m_axis handshakes

Behaviour:
- Reset (ap_rst_n=0, asynchronous):
  - m_axis_tvalid=0, m_axis_tlast=0.
  - Hold buffer = 0, so m_axis_tdata=0.
  - stat_out_beats=0, state=EMPTY.
  - s_axis_tready=1 one cycle after reset is released, never during reset.
- Hold register: buf_data, buf_last, buf_zp, all captured on an s_axis handshake. buf_zp = ctrl_zero_point at that cycle; later changes of ctrl_zero_point do not affect a held beat.
- FSM states: EMPTY, LO, HI.
  - EMPTY: s_axis_tready=1, m_axis_tvalid=0. On s handshake: capture, go to LO.
  - LO: m_axis_tvalid=1, tdata from nibbles 0..N/2-1, m_axis_tlast=0. On m handshake: go to HI. s_axis_tready=0.
  - HI: m_axis_tvalid=1, tdata from nibbles N/2..N-1, m_axis_tlast=buf_last. s_axis_tready=m_axis_tready.
    - m handshake with s handshake in the same cycle: capture the new beat, go to LO.
    - m handshake without s handshake: go to EMPTY.
- Latency: beat accepted at cycle t gives LO valid at t+1; HI is valid the cycle after the LO handshake. With m_axis_tready held at 1, sustained throughput is 1 input beat per 2 cycles with no bubbles.
- m_axis_tdata and m_axis_tlast are driven only from registered state (buf, FSM). There is no combinational path from s_axis_* to m_axis_*.
- Handshake rules:
  - m_axis_tvalid never deasserts before its handshake.
  - tdata and tlast stay stable while valid=1 and ready=0.
  - s_axis_tvalid with tready=0 is ignored; the upstream holds the beat.
- Byte conversion (default build): byte j = sign-extend(nibble) to 8 bits. Range -8..7, so 0xF maps to 0xFF and 0x8 maps to 0xF8.
- stat_out_beats increments by 1 on each m handshake and wraps modulo 2^C_COUNT_WIDTH.
- ctrl_clear has priority over an increment in the same cycle; result is 0.
- Reset mid-transfer: the held beat is discarded; there is no partial-beat recovery.

Optional Feature:
- Macro: W4A8_GEMM_UNPACK_ZP_EN.
- Defined: byte = zero-extend(nibble) - zero-extend(buf_zp), computed in 8-bit two's complement. Range -15..15, no saturation needed.
- Not defined: sign-extension only. ctrl_zero_point is unused, no buf_zp register is built, and the port still exists.

Test Plan:
- Reset then one beat, tdata nibbles k = k mod 16, tlast=1, m_axis_tready=1:
  - LO at t+1 = bytes 00,01,..,07,F8,..,FF repeating.
  - HI at t+2 = same pattern, with tlast=1 on HI only.
  - stat_out_beats=2, then FSM returns to EMPTY.
- Continuous input of 100 beats, m_axis_tready=1:
  - 200 output beats in 200 cycles after the first, with no gaps.
  - s_axis_tready toggles 0/1.
  - tlast appears only on output beat 200.
- Random m_axis_tready (50%) during LO and HI: outputs hold stable while stalled, no beat is lost or duplicated, and the scoreboard matches sign-extended nibbles.
- ZP build, ctrl_zero_point=8, nibble 0x0 gives 0xF8 and 0xF gives 0x07. Changing ctrl_zero_point to 3 while the beat is held does not change HI data.
- Assert ap_rst_n low while in HI with m_axis_tready=0:
  - m_axis_tvalid drops immediately (asynchronously).
  - After release, the next beat produces fresh LO/HI output with no stale HI.
- stat_out_beats forced near 2^32-1 via 2 beats then wraps to 0; ctrl_clear coincident with a handshake gives 0.

Source files
------------

// File: rtl/w4a8_gemm_int4_unpack.sv
// INT4 -> INT8 unpack stage: one packed beat in, two INT8 beats out (LO then HI).
// Optional W4A8_GEMM_UNPACK_ZP_EN: subtract a per-beat zero point instead of sign-extending.
module w4a8_gemm_int4_unpack #(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_COUNT_WIDTH      = 32
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  input  logic [3:0]                    ctrl_zero_point,
  input  logic                          ctrl_clear,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                          s_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic [C_COUNT_WIDTH-1:0]      stat_out_beats
);

  localparam int W  = C_AXIS_TDATA_WIDTH;
  localparam int NB = W / 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LO    = 2'd1,
    HI    = 2'd2
  } state_t;

  state_t                   r_state;
  logic [W-1:0]             r_buf_data;
  logic                     r_buf_last;
  logic                     r_rdy_en;
  logic [C_COUNT_WIDTH-1:0] r_stat;
  logic [W/2-1:0]           w_half;
  logic                     w_s_hs;
  logic                     w_m_hs;

`ifdef W4A8_GEMM_UNPACK_ZP_EN
  logic [3:0] r_buf_zp;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_buf_zp <= '0;
    end else if (w_s_hs) begin
      r_buf_zp <= ctrl_zero_point;
    end
  end
`else
  logic w_unused_zp;
  assign w_unused_zp = ^ctrl_zero_point;
`endif

  // r_rdy_en keeps tready low through reset and the first cycle after it.
  assign s_axis_tready = r_rdy_en &
                         ((r_state == EMPTY) |
                          ((r_state == HI) & m_axis_tready));
  assign m_axis_tvalid = (r_state == LO) | (r_state == HI);
  assign m_axis_tlast  = (r_state == HI) & r_buf_last;
  assign w_s_hs        = s_axis_tvalid & s_axis_tready;
  assign w_m_hs        = m_axis_tvalid & m_axis_tready;
  assign w_half        = (r_state == HI) ? r_buf_data[W-1:W/2]
                                         : r_buf_data[W/2-1:0];

  for (genvar gj = 0; gj < NB; gj++) begin : g_byte
`ifdef W4A8_GEMM_UNPACK_ZP_EN
    assign m_axis_tdata[8*gj +: 8] = {4'b0, w_half[4*gj +: 4]}
                                   - {4'b0, r_buf_zp};
`else
    assign m_axis_tdata[8*gj +: 8] = {{4{w_half[4*gj+3]}},
                                      w_half[4*gj +: 4]};
`endif
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state    <= EMPTY;
      r_buf_data <= '0;
      r_buf_last <= 1'b0;
      r_rdy_en   <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_s_hs) begin
        r_buf_data <= s_axis_tdata;
        r_buf_last <= s_axis_tlast;
      end
      unique case (r_state)
        EMPTY: if (w_s_hs) r_state <= LO;
        LO:    if (w_m_hs) r_state <= HI;
        HI: begin
          if (w_m_hs) r_state <= w_s_hs ? LO : EMPTY;
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  // Clear wins over a same-cycle increment.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_stat <= '0;
    end else if (ctrl_clear) begin
      r_stat <= '0;
    end else if (w_m_hs) begin
      r_stat <= r_stat + C_COUNT_WIDTH'(1);
    end
  end

  assign stat_out_beats = r_stat;

endmodule

// File: tb/tb_w4a8_gemm_int4_unpack.sv
// Directed bench for w4a8_gemm_int4_unpack (64-bit data, 8-bit counter).
// Zero-point checks run only when W4A8_GEMM_UNPACK_ZP_EN is defined.
module tb_w4a8_gemm_int4_unpack;

  localparam int W  = 64;
  localparam int CW = 8;
  localparam int NB = W / 8;
`ifdef W4A8_GEMM_UNPACK_ZP_EN
  localparam bit ZP = 1'b1;
  localparam logic [W-1:0] HI_PAT = 64'h0F0E0D0C0B0A0908;
`else
  localparam bit ZP = 1'b0;
  localparam logic [W-1:0] HI_PAT = 64'hFFFEFDFCFBFAF9F8;
`endif
  localparam logic [W-1:0] PAT    = 64'hFEDCBA9876543210;
  localparam logic [W-1:0] LO_PAT = 64'h0706050403020100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    zp = 4'd0;
  logic          clr = 1'b0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [W-1:0]  s_tdata = '0;
  logic          s_tlast = 1'b0;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [W-1:0]  m_tdata;
  logic          m_tlast;
  logic [CW-1:0] stat;

  int pass_cnt = 0;
  int total = 0;
  int exp_stat = 0;

  always #5 clk = ~clk;

  w4a8_gemm_int4_unpack #(
    .C_AXIS_TDATA_WIDTH(W),
    .C_COUNT_WIDTH(CW)
  ) dut (
    .ap_clk(clk),
    .ap_rst_n(rst_n),
    .ctrl_zero_point(zp),
    .ctrl_clear(clr),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tdata(s_tdata),
    .s_axis_tlast(s_tlast),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tdata(m_tdata),
    .m_axis_tlast(m_tlast),
    .stat_out_beats(stat)
  );

  function automatic logic [7:0] mb(input logic [3:0] n,
                                    input logic [3:0] z);
    mb = ZP ? ({4'b0, n} - {4'b0, z}) : {{4{n[3]}}, n};
  endfunction

  function automatic logic [W-1:0] exp_half(input logic [W-1:0] d,
                                            input bit hi,
                                            input logic [3:0] z);
    int base;
    base = hi ? W / 2 : 0;
    exp_half = '0;
    for (int j = 0; j < NB; j++)
      exp_half[8*j +: 8] = mb(d[base + 4*j +: 4], z);
  endfunction

  function automatic logic [W-1:0] mk(input int i);
    logic [31:0] h;
    h = 32'(i) * 32'h9E3779B9;
    mk = {h, ~h} ^ 64'h0F1E2D3C4B5A6978;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (s_tready !== 1'b0) $display("FAIL rst_tready got %b want 0", s_tready);
    else pass_cnt++;
    total++;
    if (m_tvalid !== 1'b0 || m_tlast !== 1'b0)
      $display("FAIL rst_valid got v=%b l=%b want 0 0", m_tvalid, m_tlast);
    else pass_cnt++;
    total++;
    if (m_tdata !== '0) $display("FAIL rst_tdata got %h want 0", m_tdata);
    else pass_cnt++;
    total++;
    if (stat !== '0) $display("FAIL rst_stat got %0d want 0", stat);
    else pass_cnt++;
    rst_n = 1'b1;
    #1;
    total++;
    if (s_tready !== 1'b0) $display("FAIL rel_tready0 got %b want 0", s_tready);
    else pass_cnt++;
    tick();
    total++;
    if (s_tready !== 1'b1) $display("FAIL rel_tready1 got %b want 1", s_tready);
    else pass_cnt++;
    exp_stat = 0;
  endtask

  task automatic test_single;
    s_tvalid = 1'b1;
    s_tdata = PAT;
    s_tlast = 1'b1;
    m_tready = 1'b1;
    tick();
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    total++;
    if (m_tvalid !== 1'b1 || m_tdata !== LO_PAT || m_tlast !== 1'b0 ||
        s_tready !== 1'b0)
      $display("FAIL single_lo got v=%b d=%h l=%b r=%b want 1 %h 0 0",
               m_tvalid, m_tdata, m_tlast, s_tready, LO_PAT);
    else pass_cnt++;
    tick();
    total++;
    if (m_tvalid !== 1'b1 || m_tdata !== HI_PAT || m_tlast !== 1'b1 ||
        s_tready !== 1'b1)
      $display("FAIL single_hi got v=%b d=%h l=%b r=%b want 1 %h 1 1",
               m_tvalid, m_tdata, m_tlast, s_tready, HI_PAT);
    else pass_cnt++;
    tick();
    exp_stat = 2;
    total++;
    if (m_tvalid !== 1'b0 || stat !== CW'(exp_stat))
      $display("FAIL single_end got v=%b stat=%0d want 0 %0d",
               m_tvalid, stat, exp_stat);
    else pass_cnt++;
  endtask

  task automatic stream(input int nbeats, input bit rnd);
    int i, outs, cyc, first, lastc, eb;
    bit gap, pst, hs_s, hs_m, hi;
    logic [W-1:0] pd;
    logic pl;
    i = 0; outs = 0; cyc = 0; first = -1; lastc = -1;
    gap = 0; pst = 0; pd = '0; pl = 0;
    s_tvalid = 1'b1;
    s_tdata = mk(0);
    s_tlast = (nbeats == 1);
    while (outs < 2 * nbeats && cyc < 5000) begin
      m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (pst) begin
        total++;
        if (m_tvalid !== 1'b1 || m_tdata !== pd || m_tlast !== pl)
          $display("FAIL stall_hold got v=%b d=%h l=%b want 1 %h %b",
                   m_tvalid, m_tdata, m_tlast, pd, pl);
        else pass_cnt++;
      end
      if (m_tvalid === 1'b1) begin
        total++;
        if (s_tready !== (outs[0] & m_tready))
          $display("FAIL s_tready got %b want %b", s_tready,
                   outs[0] & m_tready);
        else pass_cnt++;
      end
      hs_s = s_tvalid && s_tready;
      hs_m = m_tvalid && m_tready;
      if (hs_m) begin
        eb = outs / 2;
        hi = outs[0];
        total++;
        if (m_tdata !== exp_half(mk(eb), hi, 4'd0) ||
            m_tlast !== (hi && eb == nbeats - 1))
          $display("FAIL out_beat%0d got %h/%b want %h/%b", outs, m_tdata,
                   m_tlast, exp_half(mk(eb), hi, 4'd0),
                   hi && eb == nbeats - 1);
        else pass_cnt++;
        if (lastc >= 0 && cyc - lastc != 1) gap = 1;
        if (first < 0) first = cyc;
        lastc = cyc;
        outs++;
      end
      pst = m_tvalid && !m_tready;
      pd = m_tdata;
      pl = m_tlast;
      @(posedge clk);
      #1;
      cyc++;
      if (hs_s) begin
        i++;
        if (i < nbeats) begin
          s_tdata = mk(i);
          s_tlast = (i == nbeats - 1);
        end else begin
          s_tvalid = 1'b0;
          s_tlast = 1'b0;
        end
      end
    end
    total++;
    if (outs != 2 * nbeats)
      $display("FAIL out_count got %0d want %0d", outs, 2 * nbeats);
    else pass_cnt++;
    if (!rnd) begin
      total++;
      if (gap || lastc - first != 2 * nbeats - 1)
        $display("FAIL no_gap got span %0d want %0d", lastc - first + 1,
                 2 * nbeats);
      else pass_cnt++;
    end
    exp_stat = (exp_stat + 2 * nbeats) % 256;
    total++;
    if (stat !== CW'(exp_stat) || m_tvalid !== 1'b0)
      $display("FAIL stream_stat got %0d v=%b want %0d 0", stat, m_tvalid,
               exp_stat);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    stream(100, 1'b0);
  endtask

  task automatic test_stall;
    stream(40, 1'b1);
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] a, b;
    a = mk(300);
    b = mk(500);
    s_tvalid = 1'b1;
    s_tdata = a;
    s_tlast = 1'b1;
    m_tready = 1'b1;
    tick();
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    tick();
    m_tready = 1'b0;
    tick();
    total++;
    if (m_tvalid !== 1'b1 || m_tdata !== exp_half(a, 1, 4'd0) ||
        m_tlast !== 1'b1)
      $display("FAIL hi_held got v=%b d=%h l=%b want 1 %h 1", m_tvalid,
               m_tdata, m_tlast, exp_half(a, 1, 4'd0));
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (m_tvalid !== 1'b0 || m_tdata !== '0 || s_tready !== 1'b0)
      $display("FAIL async_rst got v=%b d=%h r=%b want 0 0 0", m_tvalid,
               m_tdata, s_tready);
    else pass_cnt++;
    exp_stat = 0;
    total++;
    if (stat !== '0) $display("FAIL rst_mid_stat got %0d want 0", stat);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    s_tvalid = 1'b1;
    s_tdata = b;
    m_tready = 1'b1;
    tick();
    s_tvalid = 1'b0;
    total++;
    if (m_tvalid !== 1'b1 || m_tdata !== exp_half(b, 0, 4'd0) ||
        m_tlast !== 1'b0)
      $display("FAIL fresh_lo got v=%b d=%h l=%b want 1 %h 0", m_tvalid,
               m_tdata, m_tlast, exp_half(b, 0, 4'd0));
    else pass_cnt++;
    tick();
    total++;
    if (m_tvalid !== 1'b1 || m_tdata !== exp_half(b, 1, 4'd0) ||
        m_tlast !== 1'b0)
      $display("FAIL fresh_hi got v=%b d=%h l=%b want 1 %h 0", m_tvalid,
               m_tdata, m_tlast, exp_half(b, 1, 4'd0));
    else pass_cnt++;
    tick();
    exp_stat = 2;
    total++;
    if (m_tvalid !== 1'b0 || stat !== CW'(exp_stat))
      $display("FAIL fresh_end got v=%b stat=%0d want 0 %0d", m_tvalid,
               stat, exp_stat);
    else pass_cnt++;
  endtask

`ifdef W4A8_GEMM_UNPACK_ZP_EN
  task automatic test_zp;
    zp = 4'd8;
    s_tvalid = 1'b1;
    s_tdata = PAT;
    s_tlast = 1'b0;
    m_tready = 1'b1;
    tick();
    s_tvalid = 1'b0;
    total++;
    if (m_tdata !== 64'hFFFEFDFCFBFAF9F8)
      $display("FAIL zp_lo got %h want fffefdfcfbfaf9f8", m_tdata);
    else pass_cnt++;
    tick();
    m_tready = 1'b0;
    zp = 4'd3;
    tick();
    total++;
    if (m_tvalid !== 1'b1 || m_tdata !== 64'h0706050403020100)
      $display("FAIL zp_hi_held got v=%b d=%h want 1 0706050403020100",
               m_tvalid, m_tdata);
    else pass_cnt++;
    m_tready = 1'b1;
    tick();
    zp = 4'd0;
    exp_stat = (exp_stat + 2) % 256;
    total++;
    if (m_tvalid !== 1'b0 || stat !== CW'(exp_stat))
      $display("FAIL zp_end got v=%b stat=%0d want 0 %0d", m_tvalid, stat,
               exp_stat);
    else pass_cnt++;
  endtask
`endif

  task automatic test_wrap_clear;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_stat = 0;
    total++;
    if (stat !== '0) $display("FAIL clear got %0d want 0", stat);
    else pass_cnt++;
    stream(127, 1'b0);
    stream(1, 1'b0);
    total++;
    if (stat !== '0) $display("FAIL wrap got %0d want 0", stat);
    else pass_cnt++;
    s_tvalid = 1'b1;
    s_tdata = mk(3);
    m_tready = 1'b1;
    tick();
    s_tvalid = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    total++;
    if (stat !== '0) $display("FAIL clear_prio got %0d want 0", stat);
    else pass_cnt++;
    tick();
    total++;
    if (stat !== CW'(1)) $display("FAIL after_clear got %0d want 1", stat);
    else pass_cnt++;
    exp_stat = 1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_mid();
`ifdef W4A8_GEMM_UNPACK_ZP_EN
    test_zp();
`endif
    test_wrap_clear();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1);
  end

endmodule
